adc_s2mm_framer: RTL and testbench

Captures triggered frames of dual-channel 14-bit ADC samples and streams them as 32-bit AXI4-Stream words into the PS DMA S2MM slave port (S_AXIS_S2MM_0). It sits in the ADC clock domain between the ADC input registers and the block-design DMA. Software arms it and sets the frame length. The block buffers samples in an internal FIFO so that the DMA can apply tready backpressure without the stream breaking protocol.

---
 rtl/adc_s2mm_framer.sv | 196 +++++++++++++++++++
 tb/tb_adc_s2mm_framer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_s2mm_framer.sv
`default_nettype none
// ============================================================================
// Module   : adc_s2mm_framer
// Purpose  : Captures triggered frames of dual 14-bit ADC samples and streams
//            them as 32-bit AXI4-Stream words through a fall-through FIFO.
//            Define ADC_S2MM_TRIG_EN to enable the channel-A level trigger.
// Revision : 1.0 - initial release
// ============================================================================
module adc_s2mm_framer #(
    parameter int FIFO_DEPTH = 512,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [13:0]          adc_dat_a_i,
    input  logic [13:0]          adc_dat_b_i,
    input  logic                 adc_valid_i,
    input  logic                 arm_i,
    input  logic                 force_trig_i,
    input  logic [13:0]          trig_level_i,
    input  logic [LEN_WIDTH-1:0] frame_len_i,
    input  logic                 ovf_clr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [31:0]          m_axis_tdata,
    output logic [3:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready
);

    localparam int                   c_addr_w  = $clog2(FIFO_DEPTH);
    localparam logic [c_addr_w:0]    c_ptr_one = {{c_addr_w{1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] c_len_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_armed   = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_drain   = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_wr_cnt;
    logic                 r_ovf;

    logic [c_addr_w:0]    r_wr_ptr;
    logic [c_addr_w:0]    r_rd_ptr;
    logic [32:0]          r_mem [FIFO_DEPTH];
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [31:0]          r_out_data;

    logic                 w_trig;
    logic                 w_arm_ok;
    logic                 w_wr_req;
    logic                 w_wr_en;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_last_word;
    logic                 w_fifo_rd;
    logic                 w_tlast_hs;
    logic [31:0]          w_word;

`ifdef ADC_S2MM_TRIG_EN
    logic signed [13:0]   r_prev_a;
    logic                 w_level_cross;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_a <= '0;
        end else if (adc_valid_i) begin
            r_prev_a <= adc_dat_a_i;
        end
    end

    assign w_level_cross = (r_prev_a < $signed(trig_level_i)) &&
                           ($signed(adc_dat_a_i) >= $signed(trig_level_i));
    assign w_trig        = adc_valid_i && (force_trig_i || w_level_cross);
`else
    logic                 w_unused_trig_level;

    assign w_unused_trig_level = ^trig_level_i;
    assign w_trig              = adc_valid_i && force_trig_i;
`endif

    assign w_arm_ok    = (r_state == c_st_idle) && arm_i && (frame_len_i != '0);
    // The trigger sample itself is word 0, so ARMED can also write.
    assign w_wr_req    = ((r_state == c_st_armed) && w_trig) ||
                         ((r_state == c_st_capture) && adc_valid_i);
    assign w_wr_en     = w_wr_req && !w_full;
    assign w_last_word = (r_wr_cnt == (r_len - c_len_one));
    assign w_word      = {{2{adc_dat_b_i[13]}}, adc_dat_b_i,
                          {2{adc_dat_a_i[13]}}, adc_dat_a_i};

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    assign w_fifo_rd  = !w_empty && (!r_out_valid || m_axis_tready);
    assign w_tlast_hs = r_out_valid && m_axis_tready && r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_arm_ok) begin
                    w_state_nxt = c_st_armed;
                end
            end
            c_st_armed: begin
                if (w_trig) begin
                    w_state_nxt = (w_wr_en && w_last_word) ? c_st_drain : c_st_capture;
                end
            end
            c_st_capture: begin
                if (w_wr_en && w_last_word) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_tlast_hs) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Dropped samples do not advance the count, so every frame still has len words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len    <= '0;
            r_wr_cnt <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_arm_ok) begin
                r_len    <= frame_len_i;
                r_wr_cnt <= '0;
            end else if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + c_len_one;
            end
            if (w_wr_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= {w_last_word, w_word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_fifo_rd) begin
                r_rd_ptr                 <= r_rd_ptr + c_ptr_one;
                r_out_valid              <= 1'b1;
                {r_out_last, r_out_data} <= r_mem[r_rd_ptr[c_addr_w-1:0]];
            end else if (m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy_o        = (r_state != c_st_idle);
    assign done_o        = (r_state == c_st_drain) && w_tlast_hs;
    assign overflow_o    = r_ovf;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = 4'hF;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_adc_s2mm_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_s2mm_framer
// Purpose  : Self-checking bench for adc_s2mm_framer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_s2mm_framer;

    localparam int DEPTH = 16;
    localparam int LW    = 16;
`ifdef ADC_S2MM_TRIG_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [13:0]   adc_dat_a, adc_dat_b, trig_level;
    logic          adc_valid, arm, force_trig, ovf_clr, tready;
    logic [LW-1:0] frame_len;
    logic          busy, done, overflow, tlast, tvalid;
    logic [31:0]   tdata;
    logic [3:0]    tkeep;

    int n_cmp = 0;
    int n_err = 0;
    int n_last = 0;
    int n_done = 0;
    logic [31:0] got[$];

    always #5 clk = ~clk;

    adc_s2mm_framer #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .adc_dat_a_i(adc_dat_a), .adc_dat_b_i(adc_dat_b), .adc_valid_i(adc_valid),
        .arm_i(arm), .force_trig_i(force_trig), .trig_level_i(trig_level),
        .frame_len_i(frame_len), .ovf_clr_i(ovf_clr),
        .busy_o(busy), .done_o(done), .overflow_o(overflow),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding words in a queue, tagged with the cycle they were written.
    typedef struct { logic [31:0] d; bit last; int w; } word_t;
    word_t mq[$];
    int    m_st = 0;      // 0 idle, 1 armed, 2 capture, 3 drain
    int    m_len = 0, m_cnt = 0, cyc = 0;
    bit    m_ovf = 0, m_valid = 0;
    int    m_prev = 0;

    initial begin : model
        bit hs, done_now, full, trig, req, wr, lastw;
        int fifo_cnt, ca, lv;
        logic signed [15:0] sa16, sb16;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                m_st = 0; m_len = 0; m_cnt = 0; m_ovf = 0; m_prev = 0;
            end else begin
                hs       = m_valid && tready;
                done_now = 0;
                if (hs) done_now = mq[0].last;
                fifo_cnt = mq.size() - (m_valid ? 1 : 0);
                full     = (fifo_cnt == DEPTH);
                ca       = $signed(adc_dat_a);
                lv       = $signed(trig_level);
                trig     = adc_valid && (force_trig || (TRIG_EN && m_prev < lv && ca >= lv));
                req      = (m_st == 1 && trig) || (m_st == 2 && adc_valid);
                wr       = req && !full;
                lastw    = (m_cnt == m_len - 1);
                sa16     = $signed(adc_dat_a);
                sb16     = $signed(adc_dat_b);
                case (m_st)
                    0: if (arm && frame_len != 0) begin m_st = 1; m_len = int'(frame_len); m_cnt = 0; end
                    1: if (trig) m_st = (wr && lastw) ? 3 : 2;
                    2: if (wr && lastw) m_st = 3;
                    3: if (done_now) m_st = 0;
                    default: m_st = 0;
                endcase
                if (hs) void'(mq.pop_front());
                if (wr) begin
                    mq.push_back('{d: {sb16, sa16}, last: lastw, w: cyc});
                    m_cnt++;
                end
                if (req && full) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
                if (adc_valid) m_prev = ca;
            end
            m_valid = (mq.size() > 0) && (mq[0].w < cyc);
        end
    end

    always @(negedge clk) begin : compare
        bit ed;
        ed = 0;
        if (m_valid) ed = mq[0].last && tready;
        chk("tvalid", tvalid, m_valid);
        chk("busy", busy, m_st != 0);
        chk("overflow", overflow, m_ovf);
        chk("done", done, ed);
        chk("tkeep", tkeep, 4'hF);
        if (m_valid) begin
            chk("tdata", tdata, mq[0].d);
            chk("tlast", tlast, mq[0].last);
        end
        if (tvalid && tready) begin
            got.push_back(tdata);
            if (tlast) n_last++;
        end
        if (done) n_done++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int len);
        frame_len = LW'(len);
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic sample(input int a, input int b, input bit f);
        adc_dat_a  = 14'(a);
        adc_dat_b  = 14'(b);
        adc_valid  = 1'b1;
        force_trig = f;
        step();
        adc_valid  = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while ((busy || tvalid) && k < bound) begin
            step();
            k++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic clear_log();
        got.delete();
        n_last = 0;
        n_done = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1; adc_dat_a = '0; adc_dat_b = '0; adc_valid = 1'b0; arm = 1'b0;
        force_trig = 1'b0; trig_level = '0; frame_len = '0; ovf_clr = 1'b0; tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);

        // Ramp through the level: frame starts at a=0 and holds words 0..70.
        clear_log();
        do_arm(8);
        for (int i = 0; i < 21; i++) sample(-100 + 10 * i, 5, !TRIG_EN && (i == 10));
        wait_idle("t1_idle", 50);
        chk("t1_words", got.size(), 8);
        chk("t1_word0", got[0], 32'h0005_0000);
        chk("t1_word7", got[7], 32'h0005_0046);
        chk("t1_tlasts", n_last, 1);
        chk("t1_dones", n_done, 1);

        // Sign extension of both channels.
        clear_log();
        do_arm(4);
        for (int i = 0; i < 6; i++) sample(-1, 8191, 1'b1);
        wait_idle("t2_idle", 50);
        chk("t2_words", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_data", got[i], 32'h1FFF_FFFF);
        chk("t2_tlasts", n_last, 1);

        // Overflow under backpressure: samples 17..25 are dropped.
        clear_log();
        tready = 1'b0;
        do_arm(2 * DEPTH);
        for (int i = 0; i < DEPTH + 10; i++) sample(100 + i, 0, i == 0);
        @(negedge clk);
        chk("t3_stall_data", tdata, 32'h0000_0064);
        chk("t3_stall_valid", tvalid, 1'b1);
        chk("t3_ovf", overflow, 1'b1);
        step();
        tready = 1'b1;
        repeat (3) step();
        for (int i = DEPTH + 10; i < DEPTH + 30; i++) sample(100 + i, 0, 1'b0);
        wait_idle("t3_idle", 100);
        chk("t3_words", got.size(), 2 * DEPTH);
        chk("t3_tlasts", n_last, 1);
        chk("t3_word16", got[16], 32'h0000_0074);
        chk("t3_word17", got[17], 32'h0000_007E);
        chk("t3_word31", got[31], 32'h0000_008C);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clr", overflow, 1'b0);

        // Zero-length arm is ignored; re-arm during capture keeps the length.
        step();
        do_arm(0);
        repeat (3) step();
        @(negedge clk);
        chk("t4_len0_busy", busy, 1'b0);
        step();
        clear_log();
        do_arm(3);
        sample(1, 0, 1'b1);
        frame_len = LW'(9);
        arm = 1'b1;
        sample(2, 0, 1'b0);
        arm = 1'b0;
        for (int i = 3; i < 6; i++) sample(i, 0, 1'b0);
        wait_idle("t4_idle", 50);
        chk("t4_words", got.size(), 3);
        chk("t4_word2", got[2], 32'h0000_0003);

        // Reset with words queued, then a clean frame.
        tready = 1'b0;
        do_arm(10);
        for (int i = 0; i < 4; i++) sample(10 + i, 0, i == 0);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t5_rst_tvalid", tvalid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        tready = 1'b1;
        clear_log();
        do_arm(3);
        for (int i = 0; i < 3; i++) sample(20 + i, 1, i == 0);
        wait_idle("t5_idle", 50);
        chk("t5_words", got.size(), 3);
        chk("t5_word0", got[0], 32'h0001_0014);
        chk("t5_word2", got[2], 32'h0001_0016);
        chk("t5_tlasts", n_last, 1);

        // Clear coinciding with a drop: the set wins.
        clear_log();
        tready = 1'b0;
        do_arm(2 * DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) sample(i, 0, i == 0);
        ovf_clr = 1'b1;
        sample(DEPTH + 1, 0, 1'b0);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t6_set_wins", overflow, 1'b1);
        step();
        tready = 1'b1;
        for (int i = DEPTH + 2; i < DEPTH + 40; i++) sample(i, 0, 1'b0);
        wait_idle("t6_idle", 100);
        chk("t6_words", got.size(), 2 * DEPTH);
        chk("t6_tlasts", n_last, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
